// File: rtl/hazard_controller.sv
// hazard_controller: load-use, taken-branch and stall resolution
// between the X and W stages; purely combinational.
module hazard_controller (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       stall,
  input  logic [6:0] OpcodeX,
  input  logic [6:0] OpcodeW,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       isZero,
  output logic       CWE2,
  output logic       noop,
  output logic       ForwardA,
  output logic       ForwardB,
  output logic       PCDelay
);

  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] ARI_RTYPE = 7'b0110011;

  // Clock only kept for port uniformity; nothing is clocked.
  logic unusedClock;
  assign unusedClock = Clock;

  logic wWrites;
  logic wLoad;
  logic usesRs1;
  logic usesRs2;
  logic hit1;
  logic hit2;
  logic loadUse;
  logic hold;
  logic brTaken;

  // Classify what the W instruction writes back; x0 never counts.
  always_comb begin
    wWrites = 1'b0;
    wLoad   = 1'b0;
    unique case (OpcodeW)
      ARI_RTYPE,
      ARI_ITYPE,
      LUI,
      AUIPC,
      JAL,
      JALR:    wWrites = (rd != 5'd0);
      LOAD:    wLoad   = (rd != 5'd0);
      default: ;
    endcase
  end

  // Classify which source registers the X instruction reads.
  always_comb begin
    usesRs1 = 1'b0;
    usesRs2 = 1'b0;
    unique case (OpcodeX)
      ARI_RTYPE,
      STORE,
      BRANCH: begin
        usesRs1 = 1'b1;
        usesRs2 = 1'b1;
      end
      ARI_ITYPE,
      LOAD,
      JALR:    usesRs1 = 1'b1;
      default: ;
    endcase
  end

  // Register matches, hazard detection and branch resolution.
  always_comb begin
    hit1    = usesRs1 & (rs1 == rd);
    hit2    = usesRs2 & (rs2 == rd);
    loadUse = wLoad & (hit1 | hit2);
    hold    = stall | loadUse;
    brTaken = (OpcodeX == BRANCH) & isZero;
  end

  // Output drive; reset forces a bubble with PC and X register held.
  always_comb begin
    CWE2     = ~hold;
    PCDelay  = hold;
    noop     = hold | brTaken;
    ForwardA = wWrites & hit1 & ~hold;
    ForwardB = wWrites & hit2 & ~hold;
    if (!Reset) begin
      CWE2     = 1'b0;
      PCDelay  = 1'b1;
      noop     = 1'b1;
      ForwardA = 1'b0;
      ForwardB = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed table, reset sequence and
// randomized checks against a set-based reference model.
module tb_hazard_controller;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] LD    = 7'b0000011;
  localparam logic [6:0] ST    = 7'b0100011;
  localparam logic [6:0] IT    = 7'b0010011;
  localparam logic [6:0] RT    = 7'b0110011;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       stall;
  logic [6:0] OpcodeX;
  logic [6:0] OpcodeW;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       isZero;
  logic       CWE2;
  logic       noop;
  logic       ForwardA;
  logic       ForwardB;
  logic       PCDelay;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  hazard_controller dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .stall    (stall),
    .OpcodeX  (OpcodeX),
    .OpcodeW  (OpcodeW),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .isZero   (isZero),
    .CWE2     (CWE2),
    .noop     (noop),
    .ForwardA (ForwardA),
    .ForwardB (ForwardB),
    .PCDelay  (PCDelay)
  );

  // exp bits: {CWE2, noop, ForwardA, ForwardB, PCDelay}
  typedef struct {
    string      name;
    logic       rstN;
    logic       stl;
    logic [6:0] opX;
    logic [6:0] opW;
    logic [4:0] d;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       z;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    string n, logic r, logic s,
    logic [6:0] x, logic [6:0] w,
    logic [4:0] d, logic [4:0] a,
    logic [4:0] b, logic z, logic [4:0] e);
    vec_t v;
    v.name = n; v.rstN = r; v.stl = s;
    v.opX = x; v.opW = w; v.d = d;
    v.s1 = a; v.s2 = b; v.z = z; v.exp = e;
    return v;
  endfunction

  // Reference model built from opcode sets and register lists.
  function automatic logic [4:0] model(
    logic r, logic s, logic [6:0] x,
    logic [6:0] w, logic [4:0] d,
    logic [4:0] a, logic [4:0] b, logic z);
    logic [6:0] writers[6];
    logic [6:0] rd1Users[6];
    logic [6:0] rd2Users[3];
    bit wr, ld, u1, u2, h1, h2, hold, br;
    writers  = '{RT, IT, LUI, AUIPC, JAL, JALR};
    rd1Users = '{RT, IT, LD, ST, BR, JALR};
    rd2Users = '{RT, ST, BR};
    wr = 0; u1 = 0; u2 = 0;
    foreach (writers[i])  if (writers[i] == w)  wr = 1;
    foreach (rd1Users[i]) if (rd1Users[i] == x) u1 = 1;
    foreach (rd2Users[i]) if (rd2Users[i] == x) u2 = 1;
    wr = wr && d != 0;
    ld = (w == LD) && d != 0;
    h1 = u1 && a == d;
    h2 = u2 && b == d;
    hold = s || (ld && (h1 || h2));
    br = (x == BR) && z;
    if (!r) return 5'b01001;
    return {!hold, hold || br,
            wr && h1 && !hold,
            wr && h2 && !hold, hold};
  endfunction

  task automatic drive(vec_t v);
    Reset = v.rstN; stall = v.stl;
    OpcodeX = v.opX; OpcodeW = v.opW;
    rd = v.d; rs1 = v.s1; rs2 = v.s2;
    isZero = v.z;
  endtask

  task automatic check(string n, logic [4:0] e);
    logic [4:0] got;
    got = {CWE2, noop, ForwardA, ForwardB, PCDelay};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", n, got, e);
    end
  endtask

  initial begin
    vec_t v;
    vecs.push_back(mk("rt_it_fwdA",1,0,IT,RT,1,1,2,1,5'b10100));
    vecs.push_back(mk("x0_nofwd",  1,0,IT,RT,0,0,2,1,5'b10000));
    vecs.push_back(mk("it_rt_both",1,0,RT,IT,1,1,1,0,5'b10110));
    vecs.push_back(mk("br_fwd_tkn",1,0,BR,RT,1,1,3,1,5'b11100));
    vecs.push_back(mk("br_nohit",  1,0,BR,RT,1,3,2,1,5'b11000));
    vecs.push_back(mk("br_ntkn",   1,0,BR,RT,1,1,3,0,5'b10100));
    vecs.push_back(mk("lduse_rt",  1,0,RT,LD,1,1,2,0,5'b01001));
    vecs.push_back(mk("lduse_br",  1,0,BR,LD,1,1,3,1,5'b01001));
    vecs.push_back(mk("ld_nohitR", 1,0,RT,LD,1,2,3,0,5'b10000));
    vecs.push_back(mk("ld_nohitB", 1,0,BR,LD,1,2,3,0,5'b10000));
    vecs.push_back(mk("stall",     1,1,BR,LD,1,3,2,1,5'b01001));
    vecs.push_back(mk("rst_match", 0,0,RT,RT,1,1,1,0,5'b01001));
    vecs.push_back(mk("ld_x0",     1,0,RT,LD,0,0,0,0,5'b10000));
    vecs.push_back(mk("jal_st_B",  1,0,ST,JAL,5,7,5,0,5'b10010));
    vecs.push_back(mk("x_unknown", 1,0,7'h7f,RT,1,1,1,1,5'b10000));
    vecs.push_back(mk("w_store",   1,0,RT,ST,1,1,1,0,5'b10000));
    vecs.push_back(mk("lui_jalr",  1,0,JALR,LUI,4,4,4,0,5'b10100));
    vecs.push_back(mk("x_lui",     1,0,LUI,RT,1,1,1,0,5'b10000));

    v = mk("init",1,0,RT,RT,0,0,0,0,0);
    drive(v);
    @(posedge Clock);

    foreach (vecs[i]) begin
      @(posedge Clock);
      drive(vecs[i]);
      #1 check(vecs[i].name, vecs[i].exp);
    end

    // Reset asserted mid-cycle with a live forward, then released.
    @(posedge Clock);
    drive(mk("seq",1,0,RT,RT,1,1,1,0,0));
    #1 check("seq_pre", 5'b10110);
    #2 Reset = 1'b0;
    #1 check("seq_rst", 5'b01001);
    #2 Reset = 1'b1;
    #1 check("seq_rel", 5'b10110);

    // Randomized traffic with a small register pool for collisions.
    begin
      logic [6:0] ops[10];
      ops = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, IT, RT, 7'h00};
      for (int i = 0; i < 300; i++) begin
        vec_t r;
        r.name = "rand";
        r.rstN = ($urandom_range(0, 15) != 0);
        r.stl  = ($urandom_range(0, 7) == 0);
        r.opX  = ($urandom_range(0, 9) == 0) ?
                 7'($urandom) : ops[$urandom_range(0, 9)];
        r.opW  = ($urandom_range(0, 9) == 0) ?
                 7'($urandom) : ops[$urandom_range(0, 9)];
        r.d    = 5'($urandom_range(0, 3));
        r.s1   = 5'($urandom_range(0, 3));
        r.s2   = 5'($urandom_range(0, 3));
        r.z    = 1'($urandom);
        r.exp  = model(r.rstN, r.stl, r.opX, r.opW,
                       r.d, r.s1, r.s2, r.z);
        @(posedge Clock);
        drive(r);
        #1 check("rand", r.exp);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
